// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH(15,7) error-injection path.
package bch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    OUT    = 2'd2
  } inj_state_t;

  localparam int          BCH_N        = 15;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bch_lfsr16.sv
// 16-bit right-shifting Galois LFSR with a seed load that never accepts all-zeros.
module bch_lfsr16
  import bch_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      // All-zeros is a lock-up state, so fall back to the default seed.
      state_d = (seed == 16'h0000) ? SEED : seed;
    end else if (en) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bch_error_injector.sv
// Flips a clamped number of distinct, LFSR-chosen bits in a codeword and
// presents the corrupted word, its mask and the error count downstream.
module bch_error_injector
  import bch_pkg::*;
#(
  parameter int          CW_W    = BCH_N,
  parameter int          MAX_ERR = 8,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_seed_load,
  input  logic [15:0]     cfg_seed,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [CW_W-1:0] s_data,
  input  logic [3:0]      s_num_err,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [CW_W-1:0] m_data,
  output logic [CW_W-1:0] m_err_mask,
  output logic [3:0]      m_num_err,
  output logic            busy
);

  localparam logic [3:0]      MAX_ERR_4 = 4'(MAX_ERR);
  localparam logic [CW_W-1:0] ONE_HOT_0 = {{(CW_W-1){1'b0}}, 1'b1};

  inj_state_t      state_q, state_d;
  logic [CW_W-1:0] data_q, data_d;
  logic [CW_W-1:0] mask_q, mask_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      req_q, req_d;
  logic            m_valid_q, m_valid_d;
  logic [CW_W-1:0] m_data_q, m_data_d;
  logic [CW_W-1:0] m_err_mask_q, m_err_mask_d;
  logic [3:0]      m_num_err_q, m_num_err_d;

  logic [15:0]     lfsr;
  logic [3:0]      pos;
  logic [CW_W-1:0] pos_bit;
  logic            pos_hit;
  logic [3:0]      req_clamped;
  logic            lfsr_load;
  logic            lfsr_en;

  assign lfsr_load = cfg_seed_load && (state_q == IDLE);
  assign lfsr_en   = (state_q == INJECT);

  bch_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .load  (lfsr_load),
    .seed  (cfg_seed),
    .state (lfsr)
  );

  assign pos         = lfsr[3:0];
  assign pos_bit     = ONE_HOT_0 << pos;
  // A candidate is usable only if it lies inside the word and is not yet flipped.
  assign pos_hit     = (int'(pos) < CW_W) && ((mask_q & pos_bit) == '0);
  assign req_clamped = (s_num_err > MAX_ERR_4) ? MAX_ERR_4 : s_num_err;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_err_mask_d = m_err_mask_q;
    m_num_err_d  = m_num_err_q;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          data_d = s_data;
          mask_d = '0;
          cnt_d  = req_clamped;
          req_d  = req_clamped;
          if (req_clamped == 4'd0) begin
            state_d      = OUT;
            m_valid_d    = 1'b1;
            m_data_d     = s_data;
            m_err_mask_d = '0;
            m_num_err_d  = 4'd0;
          end else begin
            state_d = INJECT;
          end
        end
      end
      INJECT: begin
        if (pos_hit) begin
          mask_d = mask_q | pos_bit;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d      = OUT;
            m_valid_d    = 1'b1;
            m_data_d     = data_q ^ mask_d;
            m_err_mask_d = mask_d;
            m_num_err_d  = req_q;
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      mask_q       <= '0;
      cnt_q        <= 4'd0;
      req_q        <= 4'd0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_err_mask_q <= '0;
      m_num_err_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_err_mask_q <= m_err_mask_d;
      m_num_err_q  <= m_num_err_d;
    end
  end

  assign s_ready    = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_err_mask = m_err_mask_q;
  assign m_num_err  = m_num_err_q;

endmodule

// File: doc/bch_error_injector.md
BCH_ERROR_INJECTOR -- requirements
Module: bch_error_injector

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: the reset asserts immediately on rst_n low and deasserts synchronously to clk.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- CW_W, 15, codeword width (BCH(15,7)).
- MAX_ERR, 8, upper clamp on injected errors.
- SEED, 16'hACE1, LFSR reset and fallback seed.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_seed_load, in, 1, one-cycle pulse that loads cfg_seed.
- cfg_seed, in, 16, LFSR seed value.
- s_valid, in, 1, input codeword valid.
- s_ready, out, 1, injector can accept a codeword.
- s_data, in, CW_W, encoded codeword from the encoder.
- s_num_err, in, 4, requested number of bit errors.
- m_valid, out, 1, corrupted codeword valid, toward the syndrome decoder.
- m_ready, in, 1, downstream accepts the codeword.
- m_data, out, CW_W, corrupted codeword (s_data XOR mask).
- m_err_mask, out, CW_W, flipped-bit positions.
- m_num_err, out, 4, number of errors actually injected.
- busy, out, 1, high in states INJECT and OUT.

Function
REQ-004 The FSM SHALL have three states, IDLE, INJECT and OUT, and SHALL be IDLE after reset.
REQ-005 s_ready SHALL equal (state==IDLE) combinationally, and no input SHALL be accepted in any other state.
REQ-006 On the IDLE handshake (s_valid && s_ready), the block SHALL capture s_data, set the remaining count to min(s_num_err, MAX_ERR), clear the mask, and go to INJECT, or directly to OUT if the count is 0.
REQ-007 LFSR:
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (tap mask 16'hB400).
- Advances exactly once per cycle while in INJECT, and only then.
REQ-008 Each INJECT cycle, the candidate position SHALL be pos = lfsr[3:0] (before the advance), and:
- If pos < CW_W and mask[pos]==0: set mask[pos] and decrement the count.
- Otherwise: the cycle is a rejection, with no mask change.
REQ-009 When a decrement brings the count to 0, the next state SHALL be OUT, so injected positions are always distinct.
REQ-010 In OUT, the outputs SHALL behave as follows:
- m_valid=1.
- m_data = captured data XOR mask.
- m_err_mask = mask.
- m_num_err = popcount(mask) = the clamped request.
- All of these registered and held stable until m_ready.
REQ-011 On m_valid && m_ready, the next state SHALL be IDLE and m_valid SHALL drop in the same edge.
REQ-012 Latency from handshake to m_valid SHALL be:
- Exactly 1 cycle for a count of 0.
- 1 + (number of INJECT cycles) otherwise, with a minimum of count+1.
REQ-013 cfg_seed_load:
- Honoured only in IDLE; ignored in INJECT and OUT.
- A zero cfg_seed SHALL load SEED instead (no lock-up).
REQ-014 If cfg_seed_load and the s_valid handshake occur in the same IDLE cycle, both SHALL take effect, and INJECT SHALL start from the new seed.
REQ-015 s_num_err > MAX_ERR SHALL be clamped to MAX_ERR silently, with no error flag.

Reset
REQ-016 While rst_n is low, the block SHALL hold:
- state=IDLE and lfsr=SEED.
- m_valid=0, m_data=0, m_err_mask=0, m_num_err=0, busy=0.
- s_ready=1, since it is derived from state.
REQ-017 A reset asserted mid-INJECT or mid-OUT SHALL drop the in-flight codeword with no output.

Structure
REQ-018 Package bch_pkg SHALL hold:
- The inj_state_t enum (IDLE=2'd0, INJECT=2'd1, OUT=2'd2).
- The BCH_N=15 constant.
- LFSR_TAPS=16'hB400.
- The default SEED.
REQ-019 The LFSR SHALL be a sub-module, bch_lfsr16, with ports clk, rst_n, en, load, seed and state.

Verification
REQ-020 Zero errors: s_data=15'h2AB5, s_num_err=0 -> m_valid 1 cycle later, m_data=15'h2AB5, m_err_mask=0, m_num_err=0.
REQ-021 Two errors: s_num_err=2, default seed -> popcount(m_err_mask)=2, m_data^15'h2AB5==m_err_mask, m_num_err=2.
REQ-022 Clamp: s_num_err=12 with MAX_ERR=8 -> exactly 8 mask bits set, all distinct, m_num_err=8.
REQ-023 Backpressure: m_ready held low 10 cycles in OUT -> m_data and m_err_mask stable, s_ready=0, concurrent s_valid not accepted.
REQ-024 Reproducibility: load cfg_seed=16'h1234 and inject s_num_err=3 twice with the same data -> identical m_err_mask; cfg_seed=0 behaves as SEED.
REQ-025 Reset mid-INJECT: rst_n pulsed low in the 2nd INJECT cycle -> m_valid=0, state IDLE, LFSR=SEED, and the next transaction is correct.
